// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one unified memory port between fetch (I) and memory stage (D).
// Ports: i_* fetch port, d_* data port, mem_* memory side, busy while ACCESS/RESP.
//
// Purpose:
//   Grants one requester at a time, latches its request, holds the memory for
//   MEM_LAT cycles, then pulses the owner's ready for one cycle with read data.
//   D wins ties unless it has already won MAX_DSTREAK grants in a row while I
//   was waiting, in which case I is forced ahead.
//
// Port summary:
//   clk, rst          clock, synchronous active-high reset
//   i_req/i_addr      fetch request (read only)
//   i_ready/i_rdata   fetch completion pulse and held fetched word
//   d_req/d_wr/d_addr/d_wdata  data request (load or store)
//   d_ready/d_rdata   data completion pulse and held load word
//   mem_enable/mem_wr/mem_addr/mem_wdata/mem_rdata  unified memory port
//   busy              high while an access or response is in progress
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LAT     = 4,
    parameter int MAX_DSTREAK = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [15:0]           i_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_ready,
    output logic [15:0]           d_rdata,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic                  busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STK_W = $clog2(MAX_DSTREAK + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STK_W-1:0]      dstreak_q, dstreak_d;
    logic                  owner_d_q, owner_d_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;

    logic                  i_ready_q, i_ready_d;
    logic [15:0]           i_rdata_q, i_rdata_d;
    logic                  d_ready_q, d_ready_d;
    logic [15:0]           d_rdata_q, d_rdata_d;
    logic                  mem_enable_q, mem_enable_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]           mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;

    logic                  grant_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dstreak_d   = dstreak_q;
        owner_d_d   = owner_d_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        mem_enable_d = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        grant_i     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    // D is preferred unless I has been passed over too often.
                    grant_i = i_req && (!d_req || dstreak_q == STK_MAX);
                    cnt_d   = CNT_INIT;
                    state_d = S_ACCESS;
                    if (grant_i) begin
                        owner_d_d = 1'b0;
                        wr_d      = 1'b0;
                        addr_d    = i_addr;
                        wdata_d   = '0;
                        dstreak_d = '0;
                    end else begin
                        owner_d_d = 1'b1;
                        wr_d      = d_wr;
                        addr_d    = d_addr;
                        wdata_d   = d_wr ? d_wdata : 16'h0000;
                        if (!i_req) begin
                            dstreak_d = '0;
                        end else if (dstreak_q != STK_MAX) begin
                            dstreak_d = dstreak_q + 1'b1;
                        end
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    // Last memory cycle: read data is valid now.
                    if (!wr_q) begin
                        if (owner_d_q) d_rdata_d = mem_rdata;
                        else           i_rdata_d = mem_rdata;
                    end
                    i_ready_d = !owner_d_q;
                    d_ready_d = owner_d_q;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Memory outputs are registered, so derive them from the next state.
        busy_d = (state_d != S_IDLE);
        if (state_d == S_ACCESS) begin
            mem_enable_d = 1'b1;
            mem_addr_d   = addr_d;
            mem_wdata_d  = wr_d ? wdata_d : 16'h0000;
            mem_wr_d     = wr_d && (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dstreak_q    <= '0;
            owner_d_q    <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_ready_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_ready_q    <= 1'b0;
            d_rdata_q    <= '0;
            mem_enable_q <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dstreak_q    <= dstreak_d;
            owner_d_q    <= owner_d_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_ready_q    <= i_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_ready_q    <= d_ready_d;
            d_rdata_q    <= d_rdata_d;
            mem_enable_q <= mem_enable_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign i_ready    = i_ready_q;
    assign i_rdata    = i_rdata_q;
    assign d_ready    = d_ready_q;
    assign d_rdata    = d_rdata_q;
    assign mem_enable = mem_enable_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_unified_mem_arbiter;

    localparam int AW   = 16;
    localparam int LAT  = 4;
    localparam int MAXD = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic [15:0]   i_rdata;
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [15:0]   d_wdata;
    logic          d_ready;
    logic [15:0]   d_rdata;
    logic          mem_enable;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          busy;

    unified_mem_arbiter #(
        .ADDR_WIDTH (AW),
        .MEM_LAT    (LAT),
        .MAX_DSTREAK(MAXD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_enable(mem_enable),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Environment memory (word addressed, bit 0 ignored) and reference copy.
    logic [15:0] env_mem [0:1023];
    logic [15:0] ref_mem [0:1023];
    assign mem_rdata = env_mem[mem_addr[10:1]];

    int n_cmp = 0;
    int n_bad = 0;

    int edge_n = 0;
    int free_at = 0;
    int g_edge = -1000;
    int streak = 0;
    bit g_d, g_wr;
    logic [15:0] g_addr, g_wdata;
    logic [15:0] exp_i = 16'h0, exp_d = 16'h0;

    int n_iready = 0, n_dready = 0, n_en = 0, n_wr = 0;
    int last_i_edge = 0, last_d_edge = 0;
    bit obs_q[$];
    bit auto_i = 0, auto_d = 0;
    int p_req = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        int e, k;
        bit gi, wen, en_x, wr_x, busy_x;
        logic [9:0] wa;
        logic [15:0] wd;
        e = edge_n;
        wen = mem_enable && mem_wr;
        wa = mem_addr[10:1];
        wd = mem_wdata;
        if (rst) begin
            g_edge = -1000;
            free_at = e + 1;
            streak = 0;
            exp_i = 16'h0;
            exp_d = 16'h0;
        end else if (e >= free_at && (i_req || d_req)) begin
            gi = i_req && (!d_req || streak == MAXD);
            g_edge = e;
            free_at = e + LAT + 2;
            g_d = !gi;
            if (gi) begin
                g_wr = 0;
                g_addr = i_addr;
                g_wdata = 16'h0;
                streak = 0;
            end else begin
                g_wr = d_wr;
                g_addr = d_addr;
                g_wdata = d_wdata;
                streak = i_req ? ((streak < MAXD) ? streak + 1 : MAXD) : 0;
            end
        end
        @(posedge clk);
        if (wen) env_mem[wa] = wd;
        #1;
        k = e - g_edge;
        edge_n++;
        if (k == LAT) begin
            if (g_wr) ref_mem[g_addr[10:1]] = g_wdata;
            else if (g_d) exp_d = ref_mem[g_addr[10:1]];
            else exp_i = ref_mem[g_addr[10:1]];
        end
        en_x = (k >= 0) && (k < LAT);
        wr_x = en_x && g_wr && (k == LAT - 1);
        busy_x = (k >= 0) && (k <= LAT);
        chk("mem_enable", mem_enable, en_x);
        chk("mem_wr", mem_wr, wr_x);
        chk("busy", busy, busy_x);
        chk("i_ready", i_ready, k == LAT && !g_d);
        chk("d_ready", d_ready, k == LAT && g_d);
        chk("i_rdata", i_rdata, exp_i);
        chk("d_rdata", d_rdata, exp_d);
        if (en_x) chk("mem_addr", mem_addr, g_addr);
        if (en_x && g_wr) chk("mem_wdata", mem_wdata, g_wdata);
        if (!busy_x) begin
            chk("idle_mem_addr", mem_addr, 0);
            chk("idle_mem_wdata", mem_wdata, 0);
        end
        if (mem_enable) n_en++;
        if (mem_wr) n_wr++;
        if (i_ready) begin
            n_iready++;
            last_i_edge = e;
            obs_q.push_back(1'b0);
        end
        if (d_ready) begin
            n_dready++;
            last_d_edge = e;
            obs_q.push_back(1'b1);
        end
        if (auto_i && (i_ready || !i_req)) begin
            if ($urandom_range(99) < p_req) begin
                i_req = 1;
                i_addr = 16'($urandom_range(0, 2047));
            end else begin
                i_req = 0;
            end
        end
        if (auto_d && (d_ready || !d_req)) begin
            if ($urandom_range(99) < p_req) begin
                d_req = 1;
                d_wr = 1'($urandom_range(0, 1));
                d_addr = 16'($urandom_range(0, 2047));
                d_wdata = 16'($urandom);
            end else begin
                d_req = 0;
            end
        end
    endtask

    task automatic wait_ready(input bit want_d, input int budget);
        bit seen;
        seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            step();
            if (want_d ? d_ready : i_ready) seen = 1;
        end
        chk(want_d ? "d_ready_timeout" : "i_ready_timeout", seen, 1);
        if (want_d) d_req = 0;
        else i_req = 0;
    endtask

    initial begin
        int t0, nen0, nwr0, nd0;
        logic [15:0] orig;
        bit pat [8];
        pat = '{1, 1, 1, 0, 1, 1, 1, 0};
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = 16'($urandom);
            ref_mem[i] = env_mem[i];
        end
        env_mem[8] = 16'hABCD;
        ref_mem[8] = 16'hABCD;
        rst = 1; i_req = 0; i_addr = '0;
        d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        step();
        step();
        rst = 0;
        step();

        // Fetch only.
        i_req = 1;
        i_addr = 16'h0010;
        t0 = edge_n;
        nen0 = n_en;
        wait_ready(0, 20);
        chk("ionly_latency", last_i_edge - t0, LAT);
        chk("ionly_enable_cycles", n_en - nen0, LAT);
        chk("ionly_rdata", i_rdata, 16'hABCD);
        step();
        step();

        // Store then load back.
        d_req = 1; d_wr = 1; d_addr = 16'h0040; d_wdata = 16'h1234;
        nwr0 = n_wr;
        wait_ready(1, 20);
        chk("store_wr_pulses", n_wr - nwr0, 1);
        step();
        chk("store_mem", env_mem[32], 16'h1234);
        d_req = 1; d_wr = 0;
        wait_ready(1, 20);
        chk("load_rdata", d_rdata, 16'h1234);
        step();

        // Simultaneous requests: D first, I next.
        i_req = 1; i_addr = 16'h0010;
        d_req = 1; d_wr = 0; d_addr = 16'h0022;
        wait_ready(1, 20);
        wait_ready(0, 20);
        chk("simul_gap", last_i_edge - last_d_edge, LAT + 2);
        step();

        // Starvation guard.
        obs_q.delete();
        auto_i = 1; auto_d = 1; p_req = 100;
        i_req = 1; d_req = 1; d_wr = 0;
        for (int n = 0; n < 8 * (LAT + 2) + 2; n++) step();
        chk("starve_count", obs_q.size() >= 8, 1);
        for (int j = 0; j < 8 && j < obs_q.size(); j++)
            chk($sformatf("starve_order_%0d", j), obs_q[j], pat[j]);
        p_req = 0;
        for (int n = 0; n < 40 && (i_req || d_req); n++) step();
        chk("starve_drain", i_req || d_req, 0);
        auto_i = 0; auto_d = 0;
        for (int n = 0; n < LAT + 3; n++) step();

        // Reset during the second access cycle of a store.
        orig = env_mem[64];
        d_req = 1; d_wr = 1; d_addr = 16'h0080; d_wdata = ~orig;
        nd0 = n_dready;
        step();
        step();
        rst = 1;
        d_req = 0;
        step();
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_mem_enable", mem_enable, 0);
        rst = 0;
        for (int n = 0; n < LAT + 3; n++) step();
        chk("rst_mem_unchanged", env_mem[64], orig);
        chk("rst_no_ready", n_dready - nd0, 0);

        // Request dropped during the access still completes once.
        d_req = 1; d_wr = 0; d_addr = 16'h0010;
        nd0 = n_dready;
        step();
        d_req = 0;
        for (int n = 0; n < LAT + 6; n++) step();
        chk("drop_ready_once", n_dready - nd0, 1);
        chk("drop_rdata", d_rdata, 16'hABCD);

        // Random traffic.
        auto_i = 1; auto_d = 1; p_req = 60;
        for (int n = 0; n < 1500; n++) step();
        p_req = 0;
        for (int n = 0; n < 40 && (i_req || d_req); n++) step();
        chk("random_drain", i_req || d_req, 0);
        for (int n = 0; n < LAT + 3; n++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
